mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the width of the data and address paths.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous reset, active-low (asserted when 0).
REQ-005 i_Req_Valid  in  1  pipeline request present.
REQ-006 o_Req_Ready  out  1  unit idle and can accept a request.
REQ-007 i_Req_Write  in  1  1 = store, 0 = load.
REQ-008 i_Req_Size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 i_Req_Signed  in  1  sign-extend sub-word loads.
REQ-010 i_Req_Address  in  DATA_WIDTH  byte address.
REQ-011 i_Req_Write_Data  in  DATA_WIDTH  store data, right-justified.
REQ-012 o_Resp_Valid  out  1  response available.
REQ-013 i_Resp_Ready  in  1  consumer accepts the response.
REQ-014 o_Resp_Read_Data  out  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 o_Resp_Error  out  1  misaligned address or illegal size.
REQ-016 o_Sig_Memory_Write_Enable  out  1  data_memory write strobe.
REQ-017 o_Sig_Memory_Read_Enable  out  1  data_memory read strobe.
REQ-018 o_Address  out  DATA_WIDTH  word-aligned memory address (low 2 bits are 0).
REQ-019 o_Write_Data  out  DATA_WIDTH  full-word memory write data.
REQ-020 i_Read_Data  in  DATA_WIDTH  data_memory read data.

Function
REQ-021 FSM states: IDLE, RD, RD_WAIT, WR, RESP.
REQ-022 o_Req_Ready SHALL be 1 only in IDLE; a request is accepted on an edge where i_Req_Valid and o_Req_Ready are both 1.
REQ-023 Address, size, signed flag and write data SHALL be registered on acceptance; later input changes SHALL have no effect.
REQ-024 Alignment rules: halfword accesses require addr[0] = 0; word accesses require addr[1:0] = 00.
REQ-025 A misaligned or size-11 request SHALL go IDLE->RESP with o_Resp_Error = 1 and data 0, and SHALL NOT assert either memory enable.
REQ-026 Load path: IDLE->RD->RD_WAIT->RESP.
REQ-027 In a load, read enable is high and the address is stable through RD and RD_WAIT; i_Read_Data is captured at the end of RD_WAIT.
REQ-028 Word store path: IDLE->WR->RESP.
REQ-029 Sub-word store path: IDLE->RD->RD_WAIT->WR->RESP (read-modify-write); WR writes the captured word with only the addressed byte or halfword lane replaced.
REQ-030 Write enable SHALL be high for exactly one cycle, in WR only.
REQ-031 Read and write enables SHALL never be high in the same cycle.
REQ-032 Byte lanes are little-endian: lane = addr[1:0] for bytes and addr[1] for halfwords.
REQ-033 Loads SHALL be zero-extended, or sign-extended when i_Req_Signed = 1; a word load returns the word unchanged.
REQ-034 Latency after the accepting edge: o_Resp_Valid high in cycle 1 for an error, cycle 2 for a word store, cycle 3 for a load, cycle 4 for a sub-word store.
REQ-035 RESP SHALL hold o_Resp_Valid, data and error stable until i_Resp_Ready = 1, then return to IDLE on that edge.
REQ-036 Memory enables and o_Address SHALL be decoded from registered state only, with no combinational path from the request inputs.

Reset
REQ-037 Reset asserted in any state SHALL immediately set state IDLE, both memory enables 0, o_Resp_Valid 0, o_Resp_Error 0, o_Resp_Read_Data 0, o_Address 0 and o_Write_Data 0, and SHALL drop any in-flight request without a write.
REQ-038 o_Req_Ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-039 A shared package SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encoding.
REQ-040 A combinational sub-module, mem_lane_align, SHALL perform store lane merge and load extraction/extension; mem_access_unit instantiates it once.

Verification
REQ-041 Scenario: word store 0xDEADBEEF @1024, then word load @1024 -> exactly one WE pulse with o_Write_Data 0xDEADBEEF; load response 0xDEADBEEF in cycle 3, error 0.
REQ-042 Scenario: byte store 0xAB @1025 over 0xDEADBEEF -> RE for 2 cycles at o_Address 1024, then one WE with 0xDEADABEF; response in cycle 4.
REQ-043 Scenario: loads after REQ-042 -> signed byte @1025 returns 0xFFFFFFAB; unsigned byte @1025 returns 0x000000AB; signed half @1026 returns 0xFFFFDEAD.
REQ-044 Scenario: word load @1026 and a size-11 request -> o_Resp_Error 1 and data 0 in cycle 1; RE and WE never asserted.
REQ-045 Scenario: i_Resp_Ready held 0 for 5 cycles -> response held stable, o_Req_Ready held 0, and a concurrent new request is not accepted.
REQ-046 Scenario: reset pulsed during RD_WAIT of a half store @1028 -> WE never asserts, the memory word is unchanged, and o_Req_Ready is 1 the cycle after release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared access-size encodings, FSM state encoding and the
//               alignment rule used by the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } mau_state_t;

  // An access is bad when its size is illegal or its address is not
  // naturally aligned for that size.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Little-endian store lane merge and load extraction/extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  input  logic [1:0]            i_addr_lo,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_merged_word,
  output logic [DATA_WIDTH-1:0] o_load_data
);

  logic [4:0]            w_byte_shift;
  logic [4:0]            w_half_shift;
  logic [DATA_WIDTH-1:0] w_byte_mask;
  logic [DATA_WIDTH-1:0] w_half_mask;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  always_comb begin
    w_byte_shift  = {i_addr_lo, 3'b000};
    w_half_shift  = {i_addr_lo[1], 4'b0000};
    w_byte_mask   = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << w_byte_shift;
    w_half_mask   = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << w_half_shift;
    w_byte        = 8'(i_word >> w_byte_shift);
    w_half        = 16'(i_word >> w_half_shift);
    o_merged_word = i_store_data;
    o_load_data   = i_word;
    case (i_size)
      SIZE_BYTE: begin
        o_merged_word = (i_word & ~w_byte_mask)
                      | ({{(DATA_WIDTH-8){1'b0}}, i_store_data[7:0]} << w_byte_shift);
        o_load_data   = {{(DATA_WIDTH-8){i_signed & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_merged_word = (i_word & ~w_half_mask)
                      | ({{(DATA_WIDTH-16){1'b0}}, i_store_data[15:0]} << w_half_shift);
        o_load_data   = {{(DATA_WIDTH-16){i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store unit with read-modify-write for
//               sub-word stores and a held response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Req_Valid,
  output logic                  o_Req_Ready,
  input  logic                  i_Req_Write,
  input  logic [1:0]            i_Req_Size,
  input  logic                  i_Req_Signed,
  input  logic [DATA_WIDTH-1:0] i_Req_Address,
  input  logic [DATA_WIDTH-1:0] i_Req_Write_Data,
  output logic                  o_Resp_Valid,
  input  logic                  i_Resp_Ready,
  output logic [DATA_WIDTH-1:0] o_Resp_Read_Data,
  output logic                  o_Resp_Error,
  output logic                  o_Sig_Memory_Write_Enable,
  output logic                  o_Sig_Memory_Read_Enable,
  output logic [DATA_WIDTH-1:0] o_Address,
  output logic [DATA_WIDTH-1:0] o_Write_Data,
  input  logic [DATA_WIDTH-1:0] i_Read_Data
);

  mau_state_t            r_state;
  mau_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_write;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_bad;
  logic [DATA_WIDTH-1:0] w_merged_word;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_accept = i_Req_Valid && (r_state == ST_IDLE);
  assign w_bad    = is_bad_access(i_Req_Size, i_Req_Address[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_size   <= SIZE_BYTE;
      r_signed <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr   <= i_Req_Address;
        r_wdata  <= i_Req_Write_Data;
        r_size   <= i_Req_Size;
        r_signed <= i_Req_Signed;
        r_write  <= i_Req_Write;
        r_err    <= w_bad;
      end
      if (r_state == ST_RD_WAIT) begin
        r_word <= i_Read_Data;
      end
    end
  end

  always_comb begin
    w_next_state              = r_state;
    o_Req_Ready               = 1'b0;
    o_Resp_Valid              = 1'b0;
    o_Resp_Error              = 1'b0;
    o_Resp_Read_Data          = '0;
    o_Sig_Memory_Read_Enable  = 1'b0;
    o_Sig_Memory_Write_Enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_Req_Ready = 1'b1;
        if (i_Req_Valid) begin
          if (w_bad) begin
            w_next_state = ST_RESP;
          end else if (i_Req_Write && (i_Req_Size == SIZE_WORD)) begin
            w_next_state = ST_WR;
          end else begin
            w_next_state = ST_RD;
          end
        end
      end
      ST_RD: begin
        o_Sig_Memory_Read_Enable = 1'b1;
        w_next_state             = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        o_Sig_Memory_Read_Enable = 1'b1;
        w_next_state             = r_write ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        o_Sig_Memory_Write_Enable = 1'b1;
        w_next_state              = ST_RESP;
      end
      ST_RESP: begin
        o_Resp_Valid     = 1'b1;
        o_Resp_Error     = r_err;
        o_Resp_Read_Data = (r_write || r_err) ? '0 : w_load_data;
        if (i_Resp_Ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Both the write merge and the load extraction work on the word captured
  // at the end of RD_WAIT, so one aligner instance serves both paths.
  mem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .i_word       (r_word),
    .i_store_data (r_wdata),
    .i_addr_lo    (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .o_merged_word(w_merged_word),
    .o_load_data  (w_load_data)
  );

  assign o_Address    = {r_addr[DATA_WIDTH-1:2], 2'b00};
  assign o_Write_Data = w_merged_word;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench with a byte-addressed reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_Req_Valid = 1'b0;
  logic        o_Req_Ready;
  logic        i_Req_Write = 1'b0;
  logic [1:0]  i_Req_Size = 2'b00;
  logic        i_Req_Signed = 1'b0;
  logic [31:0] i_Req_Address = '0;
  logic [31:0] i_Req_Write_Data = '0;
  logic        o_Resp_Valid;
  logic        i_Resp_Ready = 1'b0;
  logic [31:0] o_Resp_Read_Data;
  logic        o_Resp_Error;
  logic        o_Sig_Memory_Write_Enable;
  logic        o_Sig_Memory_Read_Enable;
  logic [31:0] o_Address;
  logic [31:0] o_Write_Data;
  logic [31:0] i_Read_Data = '0;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .i_Req_Valid              (i_Req_Valid),
    .o_Req_Ready              (o_Req_Ready),
    .i_Req_Write              (i_Req_Write),
    .i_Req_Size               (i_Req_Size),
    .i_Req_Signed             (i_Req_Signed),
    .i_Req_Address            (i_Req_Address),
    .i_Req_Write_Data         (i_Req_Write_Data),
    .o_Resp_Valid             (o_Resp_Valid),
    .i_Resp_Ready             (i_Resp_Ready),
    .o_Resp_Read_Data         (o_Resp_Read_Data),
    .o_Resp_Error             (o_Resp_Error),
    .o_Sig_Memory_Write_Enable(o_Sig_Memory_Write_Enable),
    .o_Sig_Memory_Read_Enable (o_Sig_Memory_Read_Enable),
    .o_Address                (o_Address),
    .o_Write_Data             (o_Write_Data),
    .i_Read_Data              (i_Read_Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          re;
    int          we;
    logic [31:0] wdata;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          hold_low = 1'b0;
  logic [31:0] phys [0:63];
  logic [7:0]  refm [0:255];

  int          acc_cyc = 0;
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          we_total = 0;
  logic [31:0] wdata_seen = '0;
  logic [31:0] addr_first = '0;
  bit          addr_set = 1'b0;
  bit          addr_ok = 1'b1;
  bit          resp_active = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_err = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {refm[b+8'd3], refm[b+8'd2], refm[b+8'd1], refm[b]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Memory model: one word per 4 bytes of the 256-byte region at 1024,
  // registered read so data shows up in RD_WAIT.
  initial begin
    for (int w = 0; w < 64; w++) phys[w] = init_word(32'd1024 + 32'(4 * w));
    for (int b = 0; b < 256; b++) refm[b] = 8'(init_word(32'd1024 + 32'(b & ~3)) >> (8 * (b % 4)));
    forever begin
      @(posedge clk);
      if (o_Sig_Memory_Write_Enable) phys[o_Address[7:2]] = o_Write_Data;
      if (o_Sig_Memory_Read_Enable) i_Read_Data <= phys[o_Address[7:2]];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    i_Resp_Ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Reference: byte-addressed memory, natural-alignment rule, plain arithmetic.
  task automatic model_push(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int          nb;
    logic [31:0] v;
    nb = 1 << sz;
    e = '{data: '0, err: 1'b0, lat: 0, re: 0, we: 0, wdata: '0, addr: a & ~32'd3};
    if (sz == 2'b11 || (a % nb) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!wr) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(refm[8'(a - 32'd1024 + 32'(i))]) << (8 * i));
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      e.data = v;
      e.lat  = 3;
      e.re   = 2;
    end else begin
      for (int i = 0; i < nb; i++) refm[8'(a - 32'd1024 + 32'(i))] = d[8 * i +: 8];
      e.wdata = ref_word(a & ~32'd3);
      e.we    = 1;
      e.lat   = (nb == 4) ? 2 : 4;
      e.re    = (nb == 4) ? 0 : 2;
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    i_Req_Valid      = 1'b1;
    i_Req_Write      = wr;
    i_Req_Size       = sz;
    i_Req_Signed     = sg;
    i_Req_Address    = a;
    i_Req_Write_Data = d;
    @(negedge clk);
    while (!o_Req_Ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_Req_Ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept: actual timeout required ready");
      i_Req_Valid = 1'b0;
      return;
    end
    if (push) model_push(wr, sz, sg, a, d);
    @(posedge clk);
    #1;
    i_Req_Valid      = 1'b0;
    i_Req_Write      = 1'($urandom);
    i_Req_Size       = 2'($urandom);
    i_Req_Signed     = 1'($urandom);
    i_Req_Address    = $urandom;
    i_Req_Write_Data = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_Resp_Valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_traffic(input int count);
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'd1024 + 32'($urandom_range(0, 255));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      issue(wr, sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      resp_active = 1'b0;
      re_cnt      = 0;
      we_cnt      = 0;
      continue;
    end
    if (o_Sig_Memory_Read_Enable && o_Sig_Memory_Write_Enable) begin
      checks++;
      errors++;
      $display("FAIL re_we_exclusive: actual both high required one at most");
    end
    if (o_Sig_Memory_Write_Enable) begin
      we_cnt++;
      we_total++;
      wdata_seen = o_Write_Data;
    end
    if (o_Sig_Memory_Read_Enable) re_cnt++;
    if (o_Sig_Memory_Read_Enable || o_Sig_Memory_Write_Enable) begin
      if (!addr_set) begin
        addr_first = o_Address;
        addr_set   = 1'b1;
      end else if (o_Address !== addr_first) begin
        addr_ok = 1'b0;
      end
    end
    if (o_Resp_Valid) begin
      if (!resp_active) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: actual response required none");
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          chk("resp_error", 32'(o_Resp_Error), 32'(e.err));
          chk("resp_data", o_Resp_Read_Data, e.data);
          chk("re_cycles", 32'(re_cnt), 32'(e.re));
          chk("we_pulses", 32'(we_cnt), 32'(e.we));
          if (e.we != 0) chk("write_data", wdata_seen, e.wdata);
          if (e.re + e.we > 0) chk("mem_address", addr_ok ? addr_first : ~e.addr, e.addr);
        end
        held_data = o_Resp_Read_Data;
        held_err  = o_Resp_Error;
      end else begin
        chk("held_data", o_Resp_Read_Data, held_data);
        chk("held_err", 32'(o_Resp_Error), 32'(held_err));
        chk("ready_in_resp", 32'(o_Req_Ready), 32'd0);
      end
      resp_active = !i_Resp_Ready;
    end
    if (o_Req_Ready && i_Req_Valid) begin
      acc_cyc  = cyc;
      re_cnt   = 0;
      we_cnt   = 0;
      addr_set = 1'b0;
      addr_ok  = 1'b1;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(o_Req_Ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(o_Resp_Valid), 32'd0);
    chk({tag, "_resp_error"}, 32'(o_Resp_Error), 32'd0);
    chk({tag, "_resp_data"}, o_Resp_Read_Data, 32'd0);
    chk({tag, "_re"}, 32'(o_Sig_Memory_Read_Enable), 32'd0);
    chk({tag, "_we"}, 32'(o_Sig_Memory_Write_Enable), 32'd0);
    chk({tag, "_address"}, o_Address, 32'd0);
    chk({tag, "_write_data"}, o_Write_Data, 32'd0);
  endtask

  initial begin
    int we_before;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_first_reset", 32'(o_Req_Ready), 32'd1);

    issue(1'b1, SIZE_WORD, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'd1024, 32'h0, 1'b1);
    issue(1'b1, SIZE_BYTE, 1'b0, 32'd1025, 32'h000000AB, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'd1025, 32'h0, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'd1025, 32'h0, 1'b1);
    issue(1'b0, SIZE_HALF, 1'b1, 32'd1026, 32'h0, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'd1026, 32'h0, 1'b1);
    issue(1'b0, SIZE_ILLEGAL, 1'b0, 32'd1024, 32'h0, 1'b1);
    drain();

    // Backpressure: response held for 5 cycles while a new request waits.
    hold_low = 1'b1;
    issue(1'b0, SIZE_HALF, 1'b0, 32'd1026, 32'h0, 1'b1);
    fork
      issue(1'b1, SIZE_HALF, 1'b0, 32'd1030, 32'h00005A5A, 1'b1);
      begin
        n = 0;
        while (!o_Resp_Valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 5; k++) begin
          chk("hold_valid", 32'(o_Resp_Valid), 32'd1);
          chk("hold_ready", 32'(o_Req_Ready), 32'd0);
          @(negedge clk);
        end
        hold_low = 1'b0;
      end
    join
    drain();

    random_traffic(250);
    drain();

    // Reset pulsed in RD_WAIT of a half store: no write may leak out.
    we_before = we_total;
    issue(1'b1, SIZE_HALF, 1'b0, 32'd1028, 32'h0000CAFE, 1'b0);
    @(posedge clk);
    #1;
    chk("rd_wait_re", 32'(o_Sig_Memory_Read_Enable), 32'd1);
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(o_Req_Ready), 32'd1);
    @(negedge clk);
    chk("ready_one_cycle_later", 32'(o_Req_Ready), 32'd1);
    chk("we_during_reset", 32'(we_total), 32'(we_before));
    chk("word_after_reset", phys[1], ref_word(32'd1028));

    random_traffic(50);
    drain();
    for (int w = 0; w < 64; w++) chk("final_memory", phys[w], ref_word(32'd1024 + 32'(4 * w)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
